// File: rtl/contador_regressivo_8bits_pkg.sv
// contador_regressivo_8bits: shared width default and FSM state encoding.
// Optional periodic mode selected by macro AUTO_RECARGA_EN.
package contador_regressivo_8bits_pkg;

   localparam int WIDTH_PADRAO = 8;

   typedef enum logic [1:0] {
      EST_OCIOSO = 2'b00,
      EST_CONTA  = 2'b01,
      EST_FIM    = 2'b10
   } estado_t;

endpackage

// File: rtl/contador_regressivo_8bits_if.sv
// contador_regressivo_8bits: control/data bundle between user and counter.
// The master drives load/value/enable; the counter (slave) returns status.
interface contador_regressivo_8bits_if
   import contador_regressivo_8bits_pkg::*;
#(
   parameter int WIDTH = WIDTH_PADRAO
) ();

   logic             LOAD;
   logic [WIDTH-1:0] VALOR;
   logic             ENABLE;
   logic [WIDTH-1:0] Q;
   logic             BUSY;
   logic             ZERO;
   logic             DONE;

   modport master (
      output LOAD, VALOR, ENABLE,
      input  Q, BUSY, ZERO, DONE
   );

   modport slave (
      input  LOAD, VALOR, ENABLE,
      output Q, BUSY, ZERO, DONE
   );

endinterface

// File: rtl/contador_regressivo_8bits_decrementador8bits.sv
// contador_regressivo_8bits: ripple-borrow decrementer built from gates.
// A bit flips when every lower bit is zero (borrow propagates through).
module decrementador8bits #(
   parameter int WIDTH = 8
) (
   input  wire [WIDTH-1:0] a_i,
   output wire [WIDTH-1:0] d_o
);

   wire [WIDTH-1:0] b;

   assign b[0] = 1'b1;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         xor g_x (d_o[i], a_i[i], b[i]);
         if (i < WIDTH - 1) begin : g_brw
            wire na;
            not g_n (na, a_i[i]);
            and g_a (b[i+1], b[i], na);
         end
      end
   endgenerate

endmodule

// File: rtl/contador_regressivo_8bits_flipflopbase.sv
// contador_regressivo_8bits: single-bit storage cell, no enable.
// Synchronous active-high clear; holding is done by the caller's D mux.
module flipflopbase (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   // One bit of state, cleared synchronously.
   always_ff @(posedge clk_i) begin
      if (rst_i) q_o <= 1'b0;
      else       q_o <= d_i;
   end

endmodule

// File: rtl/contador_regressivo_8bits.sv
// contador_regressivo_8bits: loadable down-counter with one-cycle DONE.
// Define AUTO_RECARGA_EN for periodic reload from the last loaded value.
module contador_regressivo_8bits
   import contador_regressivo_8bits_pkg::*;
#(
   parameter int WIDTH = WIDTH_PADRAO
) (
   input logic                     CLOCK,
   input logic                     RESET,
   contador_regressivo_8bits_if.slave bus
);

   localparam logic [WIDTH-1:0] UM = WIDTH'(1);

   logic [WIDTH-1:0] q_q, q_d, dec;
   estado_t          est_q, est_d;
   logic             busy_q, done_q;
`ifdef AUTO_RECARGA_EN
   logic [WIDTH-1:0] rec_q, rec_d;
`endif

   decrementador8bits #(.WIDTH(WIDTH)) u_dec (
      .a_i (q_q),
      .d_o (dec)
   );

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_ff
         flipflopbase u_ff (
            .clk_i (CLOCK),
            .rst_i (RESET),
            .d_i   (q_d[i]),
            .q_o   (q_q[i])
         );
      end
   endgenerate

   // Next count, next state and reload value; LOAD wins over ENABLE.
   always_comb begin
      est_d = est_q;
      q_d   = q_q;
`ifdef AUTO_RECARGA_EN
      rec_d = rec_q;
`endif
      case (est_q)
         EST_OCIOSO, EST_FIM: begin
            if (bus.LOAD) begin
               q_d   = bus.VALOR;
               est_d = (bus.VALOR == '0) ? EST_FIM : EST_CONTA;
`ifdef AUTO_RECARGA_EN
               rec_d = bus.VALOR;
`endif
            end else if (est_q == EST_FIM) begin
`ifdef AUTO_RECARGA_EN
               if (rec_q != '0) begin
                  q_d   = rec_q;
                  est_d = EST_CONTA;
               end else begin
                  est_d = EST_OCIOSO;
               end
`else
               est_d = EST_OCIOSO;
`endif
            end
         end
         EST_CONTA: begin
            if (bus.LOAD) begin
               q_d   = bus.VALOR;
               est_d = (bus.VALOR == '0) ? EST_FIM : EST_CONTA;
`ifdef AUTO_RECARGA_EN
               rec_d = bus.VALOR;
`endif
            end else if (bus.ENABLE) begin
               if (q_q > UM) begin
                  q_d = dec;
               end else begin
                  q_d   = '0;
                  est_d = EST_FIM;
               end
            end
         end
         default: begin
            q_d   = '0;
            est_d = EST_OCIOSO;
         end
      endcase
   end

   // State register with BUSY/DONE registered from the next state.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         est_q  <= EST_OCIOSO;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef AUTO_RECARGA_EN
         rec_q  <= '0;
`endif
      end else begin
         est_q  <= est_d;
         busy_q <= (est_d == EST_CONTA);
         done_q <= (est_d == EST_FIM);
`ifdef AUTO_RECARGA_EN
         rec_q  <= rec_d;
`endif
      end
   end

   assign bus.Q    = q_q;
   assign bus.BUSY = busy_q;
   assign bus.DONE = done_q;
   assign bus.ZERO = (q_q == '0);

endmodule

// File: tb/tb_contador_regressivo_8bits.sv
// Bench for contador_regressivo_8bits: directed vectors, queued expectations.
// Covers AUTO_RECARGA_EN and one-shot builds in the final section.
module tb_contador_regressivo_8bits;

   typedef struct packed {
      logic [7:0] q;
      logic       busy;
      logic       done;
   } exp_t;

   logic CLOCK = 1'b0;
   logic RESET;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   contador_regressivo_8bits_if #(.WIDTH(8)) bus_if ();

   contador_regressivo_8bits #(.WIDTH(8)) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus_if.slave)
   );

   always #5 CLOCK = ~CLOCK;

   // Drive one cycle of inputs and queue the state expected after the edge.
   task automatic cyc(input logic r, input logic ld, input logic [7:0] v,
                      input logic en, input logic [7:0] eq,
                      input logic eb, input logic ed);
      exp_t e;
      @(negedge CLOCK);
      RESET         = r;
      bus_if.LOAD   = ld;
      bus_if.VALOR  = v;
      bus_if.ENABLE = en;
      e.q    = eq;
      e.busy = eb;
      e.done = ed;
      sb.push_back(e);
   endtask

   // Monitor: after every edge with a pending expectation, compare.
   initial begin
      exp_t e;
      logic ez;
      forever begin
         @(posedge CLOCK);
         #1;
         if (sb.size() > 0) begin
            e  = sb.pop_front();
            ez = (e.q == 8'h00);
            total++;
            if (bus_if.Q !== e.q || bus_if.BUSY !== e.busy ||
                bus_if.DONE !== e.done || bus_if.ZERO !== ez) begin
               bad++;
               $display("FAIL step%0d got Q=%h B=%b D=%b Z=%b want Q=%h B=%b D=%b Z=%b",
                        total, bus_if.Q, bus_if.BUSY, bus_if.DONE, bus_if.ZERO,
                        e.q, e.busy, e.done, ez);
            end
         end
      end
   end

   initial begin
      RESET         = 1'b1;
      bus_if.LOAD   = 1'b0;
      bus_if.VALOR  = 8'h00;
      bus_if.ENABLE = 1'b0;

      // Reset, with LOAD in the same cycle ignored.
      cyc(1, 0, 8'h00, 0, 8'h00, 0, 0);
      cyc(1, 1, 8'h55, 1, 8'h00, 0, 0);

      // Basic countdown from 5.
      cyc(0, 1, 8'h05, 1, 8'h05, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h04, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h03, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h02, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h01, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 1);

      // Load from FIM, then enable gaps 1,0,0,1,1.
      cyc(0, 1, 8'h03, 1, 8'h03, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h02, 1, 0);
      cyc(0, 0, 8'h00, 0, 8'h02, 1, 0);
      cyc(0, 0, 8'h00, 0, 8'h02, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h01, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 1);

      // Zero load: DONE next cycle, BUSY never high; ENABLE ignored idle.
      cyc(0, 1, 8'h00, 1, 8'h00, 0, 1);
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 0);

      // Mid-count reload wins over ENABLE.
      cyc(0, 1, 8'h12, 1, 8'h12, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h11, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h10, 1, 0);
      cyc(0, 1, 8'h02, 1, 8'h02, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h01, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 1);

      // Full-scale load: 255 enabled cycles to DONE.
      cyc(0, 1, 8'hFF, 1, 8'hFF, 1, 0);
      for (int k = 1; k < 255; k++)
         cyc(0, 0, 8'h00, 1, 8'(255 - k), 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 1);

      // Reset mid-count at 0x37 overrides LOAD.
      cyc(0, 1, 8'h40, 1, 8'h40, 1, 0);
      for (int k = 1; k <= 9; k++)
         cyc(0, 0, 8'h00, 1, 8'(8'h40 - k), 1, 0);
      cyc(1, 1, 8'h99, 1, 8'h00, 0, 0);

      // Hold with ENABLE low in CONTA.
      cyc(0, 1, 8'h03, 0, 8'h03, 1, 0);
      cyc(0, 0, 8'h00, 0, 8'h03, 1, 0);

      // Run to terminal, then periodic or one-shot behaviour.
      cyc(0, 0, 8'h00, 1, 8'h02, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h01, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 1);
`ifdef AUTO_RECARGA_EN
      cyc(0, 0, 8'h00, 1, 8'h03, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h02, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h01, 1, 0);
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 1);
      cyc(0, 0, 8'h00, 1, 8'h03, 1, 0);
`else
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 0);
      cyc(0, 0, 8'h00, 1, 8'h00, 0, 0);
`endif

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 10 && sb.size() > 0; k++)
         @(negedge CLOCK);
      if (sb.size() > 0) begin
         bad++;
         $display("FAIL drain got pending=%0d want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/contador_regressivo_8bits.md
Name: contador_regressivo_8bits

Overview:
- Loadable 8-bit down-counter (countdown timer), the complement of the free-running up-counter.
- Loads a start value, decrements while ENABLE=1, and signals terminal count with a one-cycle DONE pulse.
- Used by the RPN ALU control path for fixed-length multi-cycle operations (shift/iterate loops) and display timing.

Parameters:
- WIDTH, 8, counter/data width in bits; all widths below are WIDTH.

Ports:
- CLOCK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- LOAD  input  1  load request; samples VALOR on the next rising edge.
- VALOR  input  8  start value for the countdown.
- ENABLE  input  1  count qualifier; 1 = decrement, 0 = hold.
- Q  output  8  current count, registered.
- BUSY  output  1  1 while in state CONTA.
- ZERO  output  1  1 when Q==0, combinational from Q.
- DONE  output  1  one-cycle terminal-count pulse, registered.

Behaviour:
- Interface: one clock, CLOCK; reset RESET is synchronous and active-high.
- Reset:
  - RESET=1 at an edge: Q=0, state OCIOSO, BUSY=0, DONE=0; ZERO=1 follows from Q.
  - Reload register = 0.
  - RESET overrides LOAD and ENABLE, including mid-count.
- States: OCIOSO (idle), CONTA (counting), FIM (terminal, one cycle).
- OCIOSO:
  - LOAD=1: Q<=VALOR and reload register <= VALOR.
  - If VALOR!=0, go to CONTA. If VALOR==0, go to FIM, so DONE pulses one cycle after the load edge.
  - ENABLE is ignored in OCIOSO; Q holds.
- CONTA:
  - LOAD=1 has priority over ENABLE: reload exactly as in OCIOSO (restart; VALOR==0 goes to FIM).
  - Otherwise, ENABLE=1 and Q>1: Q<=Q-1 and stay in CONTA.
  - Otherwise, ENABLE=1 and Q==1: Q<=0 and go to FIM.
  - ENABLE=0: Q holds and the state holds.
- FIM:
  - DONE=1 and BUSY=0 for exactly one cycle; Q==0.
  - Next state is OCIOSO, unless LOAD=1, which is handled as from OCIOSO.
- Latency: after the load edge with VALOR=N>0 and ENABLE held at 1, Q reaches 0 and DONE is high N cycles later.
- Arithmetic: modulo 2^WIDTH. Underflow below 0 cannot occur, because CONTA never decrements from 0.
- Outputs are glitch-free registers, except ZERO, which is decoded from Q.

Optional Feature:
- Macro: AUTO_RECARGA_EN
- Defined: in FIM, if the reload register is nonzero, Q<=reload register and go to CONTA (periodic mode).
  - Period = N+1 enabled cycles; DONE pulses once per period.
  - LOAD in FIM overrides the auto-reload.
  - A reload value of 0 returns to OCIOSO.
- Undefined: one-shot; FIM always exits to OCIOSO. The reload register may be omitted.

Decomposition:
- Shared package:
  - WIDTH default.
  - State encoding constants EST_OCIOSO=2'b00, EST_CONTA=2'b01, EST_FIM=2'b10. 2'b11 is illegal and recovers to OCIOSO.
- Sub-module decrementador8bits: structural borrow chain, the dual of the up-counter toggle chain.
  - B[0]=1, B[i]=B[i-1]&~Q[i-1], D[i]=Q[i]^B[i].
  - Built from gate primitives and instanced in the datapath.
- Storage uses the existing flipflopbase per bit.
  - flipflopbase has no enable, so hold is done with a mux in front of D.

Test Plan:
- Reset check: RESET=1 mid-count at Q=0x37 -> next edge Q=0x00, BUSY=0, DONE=0, ZERO=1; LOAD asserted in the same cycle is ignored.
- Basic countdown: LOAD with VALOR=5, then ENABLE=1 -> Q=5,4,3,2,1,0 on successive cycles; DONE high only in the cycle Q==0; BUSY falls with DONE.
- Enable gaps: VALOR=3, ENABLE toggled 1,0,0,1,1 -> Q=3,2,2,2,1,0; DONE pulses exactly once.
- Zero and full-scale loads: VALOR=0 -> DONE the next cycle, BUSY never high. VALOR=0xFF -> 255 enabled cycles to DONE.
- Mid-count reload: at Q=0x10, LOAD with VALOR=0x02 and ENABLE=1 -> Q=0x02 (no decrement that cycle), then 1, 0, DONE.
- With AUTO_RECARGA_EN: VALOR=3, ENABLE=1 held -> Q=3,2,1,0,3,2,1,0…; DONE every 4th cycle. Without the macro: Q stays 0 after the first DONE.
